// File: rtl/ip_checksum_ttl_rewrite_pkg.sv
// Shared constants, types and helpers for the IPv4 checksum check / TTL rewrite stage.
// Field positions are bit indices into beat 0 of a 256-bit stream word (bit 255 = first byte MSB).
package ip_checksum_ttl_rewrite_pkg;

  localparam int DATA_W = 256;
  localparam int STRB_W = 32;
  localparam int USER_W = 128;

  localparam int ETHERTYPE_HI = 159;
  localparam int ETHERTYPE_LO = 144;
  localparam int TTL_HI       = 79;
  localparam int TTL_LO       = 72;
  localparam int PROTO_HI     = 71;
  localparam int PROTO_LO     = 64;
  localparam int CSUM_HI      = 63;
  localparam int CSUM_LO      = 48;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  typedef enum logic [2:0] {
    WAIT_H0   = 3'd0,
    WAIT_H1   = 3'd1,
    EMIT_H0   = 3'd2,
    EMIT_H1   = 3'd3,
    EMIT_LAST = 3'd4,
    PAYLOAD   = 3'd5
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/ip_checksum_ttl_rewrite_if.sv
// AXI4-Stream bundle used for both the input and output side of the rewrite stage.
interface ip_checksum_ttl_rewrite_if;
  import ip_checksum_ttl_rewrite_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/ip_checksum_ttl_rewrite_csum_fold16.sv
// Ones'-complement fold of a 33-bit sum down to 16 bits with full end-around carry.
module ip_checksum_ttl_rewrite_csum_fold16 (
  input  logic [32:0] sum_i,
  output logic [15:0] fold_o
);

  logic [17:0] f1;
  logic [16:0] f2;

  assign f1     = {2'b00, sum_i[15:0]} + {1'b0, sum_i[32:16]};
  // second carry can still ripple out of the low half, hence a third add
  assign f2     = {1'b0, f1[15:0]} + {15'd0, f1[17:16]};
  assign fold_o = f2[15:0] + {15'd0, f2[16]};

endmodule

// File: rtl/ip_checksum_ttl_rewrite.sv
// Validates the IPv4 header checksum from upstream partial sums, decrements TTL with an
// incremental checksum update, and tags bad-checksum / TTL-expired / runt packets for the CPU path.
module ip_checksum_ttl_rewrite
  import ip_checksum_ttl_rewrite_pkg::*;
#(
  parameter int EXC_BIT_POS = 32
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_RESET,
  ip_checksum_ttl_rewrite_if.slave  s_axis,
  ip_checksum_ttl_rewrite_if.master m_axis,
  input  logic [31:0]               csum_a,
  input  logic [31:0]               csum_b,
  output logic [31:0]               bad_csum_count,
  output logic [31:0]               ttl_exp_count,
  output logic [31:0]               runt_count
);

  // state     | meaning
  // WAIT_H0   | accept header beat 0
  // WAIT_H1   | accept header beat 1, evaluate checksum/TTL, rewrite beat 0
  // EMIT_H0   | present (possibly rewritten) beat 0
  // EMIT_H1   | present beat 1 unchanged
  // EMIT_LAST | present a single-beat (runt) packet
  // PAYLOAD   | combinational pass-through until TLAST
  state_e state_q, state_d;

  beat_t       h0_q, h1_q, h0_mod, s_beat, m_out;
  logic [31:0] bad_q, ttl_exp_q, runt_q;
  logic        s_tready, m_tvalid;

  logic [15:0] fold_ab, fold_rw, hc, m_old, m_new;
  logic [7:0]  ttl;
  logic [17:0] rw_sum;
  logic        is_ipv4, csum_ok, flag_bad, flag_ttl, do_rw;
  logic        h0_take, h1_take;

  assign s_beat = {s_axis.tdata, s_axis.tstrb, s_axis.tuser, s_axis.tlast};

  assign ttl     = h0_q.data[TTL_HI:TTL_LO];
  assign hc      = h0_q.data[CSUM_HI:CSUM_LO];
  assign m_old   = {ttl, h0_q.data[PROTO_HI:PROTO_LO]};
  assign m_new   = {ttl - 8'd1, h0_q.data[PROTO_HI:PROTO_LO]};
  assign rw_sum  = {2'b00, ~hc} + {2'b00, ~m_old} + {2'b00, m_new};
  assign is_ipv4 = (h0_q.data[ETHERTYPE_HI:ETHERTYPE_LO] == ETHERTYPE_IPV4);

  ip_checksum_ttl_rewrite_csum_fold16 u_fold_valid (
    .sum_i  ({1'b0, csum_a} + {1'b0, csum_b}),
    .fold_o (fold_ab)
  );

  ip_checksum_ttl_rewrite_csum_fold16 u_fold_rw (
    .sum_i  ({15'd0, rw_sum}),
    .fold_o (fold_rw)
  );

  // a bad checksum masks the TTL check so each packet lands in exactly one counter
  assign csum_ok  = (fold_ab == 16'hFFFF);
  assign flag_bad = is_ipv4 && !csum_ok;
  assign flag_ttl = is_ipv4 && csum_ok && (ttl <= 8'd1);
  assign do_rw    = is_ipv4 && csum_ok && (ttl > 8'd1);

  always_comb begin
    h0_mod = h0_q;
    if (do_rw) begin
      h0_mod.data[TTL_HI:TTL_LO]   = ttl - 8'd1;
      h0_mod.data[CSUM_HI:CSUM_LO] = ~fold_rw;
    end
    if (flag_bad || flag_ttl) h0_mod.user[EXC_BIT_POS] = 1'b1;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) state_q <= WAIT_H0;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_out    = '0;
    case (state_q)
      WAIT_H0: begin
        s_tready = 1'b1;
        if (s_axis.tvalid) state_d = s_axis.tlast ? EMIT_LAST : WAIT_H1;
      end
      WAIT_H1: begin
        s_tready = 1'b1;
        if (s_axis.tvalid) state_d = EMIT_H0;
      end
      EMIT_H0: begin
        m_tvalid = 1'b1;
        m_out    = h0_q;
        if (m_axis.tready) state_d = EMIT_H1;
      end
      EMIT_H1: begin
        m_tvalid = 1'b1;
        m_out    = h1_q;
        if (m_axis.tready) state_d = h1_q.last ? WAIT_H0 : PAYLOAD;
      end
      EMIT_LAST: begin
        m_tvalid = 1'b1;
        m_out    = h0_q;
        if (m_axis.tready) state_d = WAIT_H0;
      end
      PAYLOAD: begin
        s_tready = m_axis.tready;
        m_tvalid = s_axis.tvalid;
        m_out    = s_beat;
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) state_d = WAIT_H0;
      end
      default: state_d = WAIT_H0;
    endcase
    if (AXI_RESET) begin
      s_tready = 1'b0;
      m_tvalid = 1'b0;
    end
  end

  assign h0_take = (state_q == WAIT_H0) && s_axis.tvalid;
  assign h1_take = (state_q == WAIT_H1) && s_axis.tvalid;

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      h0_q      <= '0;
      h1_q      <= '0;
      bad_q     <= '0;
      ttl_exp_q <= '0;
      runt_q    <= '0;
    end else begin
      if (h0_take) begin
        h0_q <= s_beat;
        if (s_axis.tlast) h0_q.user[EXC_BIT_POS] <= 1'b1;
      end
      if (h1_take) begin
        h1_q <= s_beat;
        h0_q <= h0_mod;
      end
      runt_q    <= sat_inc(runt_q, h0_take && s_axis.tlast);
      bad_q     <= sat_inc(bad_q, h1_take && flag_bad);
      ttl_exp_q <= sat_inc(ttl_exp_q, h1_take && flag_ttl);
    end
  end

  assign s_axis.tready = s_tready;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tdata  = m_out.data;
  assign m_axis.tstrb  = m_out.strb;
  assign m_axis.tuser  = m_out.user;
  assign m_axis.tlast  = m_out.last;

  assign bad_csum_count = bad_q;
  assign ttl_exp_count  = ttl_exp_q;
  assign runt_count     = runt_q;

endmodule

// File: tb/tb_ip_checksum_ttl_rewrite.sv
// Bench for ip_checksum_ttl_rewrite: directed vector table, hand sequences for stall/latency/reset,
// and random back-to-back packets checked against an arithmetic reference model.
module tb_ip_checksum_ttl_rewrite;
  import ip_checksum_ttl_rewrite_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] csum_a = '0, csum_b = '0;
  logic [31:0] bad_cnt, ttl_cnt, runt_cnt;

  ip_checksum_ttl_rewrite_if s_if ();
  ip_checksum_ttl_rewrite_if m_if ();

  ip_checksum_ttl_rewrite #(.EXC_BIT_POS(32)) dut (
    .AXI_ACLK       (clk),
    .AXI_RESET      (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .csum_a         (csum_a),
    .csum_b         (csum_b),
    .bad_csum_count (bad_cnt),
    .ttl_exp_count  (ttl_cnt),
    .runt_count     (runt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] et;
    logic [7:0]  ttl;
    logic [15:0] hc;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [7:0]  ettl;
    logic [15:0] ehc;
    bit          eexc;
    int          dbad;
    int          dttl;
    int          drunt;
  } vec_t;

  int          checks = 0, failures = 0;
  int          rdy_mode = 0;
  int unsigned e_bad = 0, e_ttl = 0, e_runt = 0;
  beat_t       cur_pkt[$], exp_q[$], out_q[$];
  vec_t        vecs[10];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input beat_t act, input beat_t exp, input string name);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual data=%h user=%h strb=%h last=%b expected data=%h user=%h strb=%h last=%b",
               name, act.data, act.user, act.strb, act.last, exp.data, exp.user, exp.strb, exp.last);
    end
  endtask

  function automatic longint unsigned oc_fold(input longint unsigned x);
    while (x > 64'hFFFF) x = (x & 64'hFFFF) + (x >> 16);
    return x;
  endfunction

  task automatic build_pkt(input logic [15:0] et, input logic [7:0] ttl, input logic [15:0] hc, input int n);
    beat_t b;
    cur_pkt.delete();
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom();
      for (int w = 0; w < 4; w++) b.user[w*32 +: 32] = $urandom();
      b.user[32] = 1'b0;
      b.strb     = (i == n - 1) ? 32'($urandom()) : '1;
      b.last     = (i == n - 1);
      if (i == 0) begin
        b.data[159:144] = et;
        b.data[143:80]  = 64'h4500_0073_0000_4000;
        b.data[79:72]   = ttl;
        b.data[71:64]   = 8'h11;
        b.data[63:48]   = hc;
      end
      cur_pkt.push_back(b);
    end
  endtask

  // Reference: sum check, TTL rule and RFC1624 eq.3 in plain integer arithmetic.
  task automatic model_pkt(input logic [31:0] a, input logic [31:0] b, output int dbad, output int dttl, output int drunt);
    beat_t           b0;
    int unsigned     ttl;
    longint unsigned hc, m_old, m_new, x;
    dbad = 0; dttl = 0; drunt = 0;
    b0 = cur_pkt[0];
    ttl = b0.data[79:72];
    hc  = {48'd0, b0.data[63:48]};
    if (cur_pkt.size() == 1) begin
      b0.user[32] = 1'b1;
      drunt = 1;
    end else if (b0.data[159:144] == 16'h0800) begin
      if (oc_fold({32'd0, a} + {32'd0, b}) != 64'hFFFF) begin
        b0.user[32] = 1'b1;
        dbad = 1;
      end else if (ttl <= 1) begin
        b0.user[32] = 1'b1;
        dttl = 1;
      end else begin
        m_old = ttl * 256 + b0.data[71:64];
        m_new = (ttl - 1) * 256 + b0.data[71:64];
        x = (64'hFFFF - hc) + (64'hFFFF - m_old) + m_new;
        b0.data[79:72] = 8'(ttl - 1);
        b0.data[63:48] = 16'(64'hFFFF - oc_fold(x));
      end
    end
    exp_q.push_back(b0);
    for (int i = 1; i < cur_pkt.size(); i++) exp_q.push_back(cur_pkt[i]);
  endtask

  task automatic send_beat(input beat_t b);
    bit done;
    done = 1'b0;
    s_if.tdata  = b.data;
    s_if.tstrb  = b.strb;
    s_if.tuser  = b.user;
    s_if.tlast  = b.last;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (s_if.tready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_tready expected=tready");
    end
  endtask

  task automatic send_pkt(input logic [31:0] a, input logic [31:0] b);
    csum_a = a;
    csum_b = b;
    for (int i = 0; i < cur_pkt.size(); i++) send_beat(cur_pkt[i]);
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 5000 && out_q.size() < n; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk(out_q.size() == n, "beat_count", 64'(out_q.size()), 64'(n));
  endtask

  task automatic compare_clear();
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) chk_beat(out_q[i], exp_q[i], "beat");
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counters();
    chk(bad_cnt == e_bad,   "bad_csum_count", 64'(bad_cnt),  64'(e_bad));
    chk(ttl_cnt == e_ttl,   "ttl_exp_count",  64'(ttl_cnt),  64'(e_ttl));
    chk(runt_cnt == e_runt, "runt_count",     64'(runt_cnt), 64'(e_runt));
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ~m_if.tready;
        default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: records accepted beats and checks held outputs stay put under backpressure.
  initial begin
    beat_t held, cur;
    bit    stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      cur = {m_if.tdata, m_if.tstrb, m_if.tuser, m_if.tlast};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk(m_if.tvalid == 1'b1, "hold_valid", 64'(m_if.tvalid), 64'd1);
          chk_beat(cur, held, "hold_stable");
        end
        if (m_if.tvalid && m_if.tready) out_q.push_back(cur);
        stall = m_if.tvalid && !m_if.tready;
        held  = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int db, dt, dr;
    logic [31:0] ra, rb;
    logic [15:0] r16, et;
    logic [7:0]  rttl;
    beat_t       first;

    vecs[0] = '{16'h0800, 8'h40, 16'hB861, 32'h0002FFFD, 32'h0,        3, 8'h3F, 16'hB961, 1'b0, 0, 0, 0};
    vecs[1] = '{16'h0800, 8'h40, 16'hB861, 32'h0000FFFE, 32'h0,        3, 8'h40, 16'hB861, 1'b1, 1, 0, 0};
    vecs[2] = '{16'h0800, 8'h01, 16'hB861, 32'h0000FFFF, 32'h0,        2, 8'h01, 16'hB861, 1'b1, 0, 1, 0};
    vecs[3] = '{16'h0800, 8'h00, 16'hB861, 32'h00008000, 32'h00007FFF, 2, 8'h00, 16'hB861, 1'b1, 0, 1, 0};
    vecs[4] = '{16'h0806, 8'h40, 16'hB861, 32'h0000FFFE, 32'h0,        3, 8'h40, 16'hB861, 1'b0, 0, 0, 0};
    vecs[5] = '{16'h0800, 8'h40, 16'hB861, 32'h0002FFFD, 32'h0,        1, 8'h40, 16'hB861, 1'b1, 0, 0, 1};
    vecs[6] = '{16'h0800, 8'h01, 16'hB861, 32'h00001234, 32'h0,        2, 8'h01, 16'hB861, 1'b1, 1, 0, 0};
    vecs[7] = '{16'h0800, 8'h02, 16'h1234, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 8'h01, 16'h1334, 1'b0, 0, 0, 0};
    vecs[8] = '{16'h0800, 8'h40, 16'hB861, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 8'h3F, 16'hB961, 1'b0, 0, 0, 0};
    vecs[9] = '{16'h0806, 8'h01, 16'h0000, 32'h0,        32'h0,        2, 8'h01, 16'h0000, 1'b0, 0, 0, 0};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0; s_if.tlast = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(s_if.tready == 1'b0, "reset_s_tready", 64'(s_if.tready), 64'd0);
    chk(m_if.tvalid == 1'b0, "reset_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check_counters();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk(s_if.tready == 1'b1, "idle_s_tready", 64'(s_if.tready), 64'd1);
    @(posedge clk); #1;

    // directed vector table
    for (int v = 0; v < 10; v++) begin
      build_pkt(vecs[v].et, vecs[v].ttl, vecs[v].hc, vecs[v].n);
      model_pkt(vecs[v].a, vecs[v].b, db, dt, dr);
      send_pkt(vecs[v].a, vecs[v].b);
      s_if.tvalid = 1'b0;
      wait_out(vecs[v].n);
      if (out_q.size() > 0) begin
        first = out_q[0];
        chk(first.data[79:72] == vecs[v].ettl, $sformatf("vec%0d_ttl", v), 64'(first.data[79:72]), 64'(vecs[v].ettl));
        chk(first.data[63:48] == vecs[v].ehc,  $sformatf("vec%0d_hc", v),  64'(first.data[63:48]), 64'(vecs[v].ehc));
        chk(first.user[32] == vecs[v].eexc,    $sformatf("vec%0d_exc", v), 64'(first.user[32]),    64'(vecs[v].eexc));
      end
      compare_clear();
      e_bad  += vecs[v].dbad;
      e_ttl  += vecs[v].dttl;
      e_runt += vecs[v].drunt;
      check_counters();
    end

    // beat 0 must be on the output the cycle after beat 1 is accepted
    build_pkt(16'h0800, 8'h40, 16'hB861, 2);
    model_pkt(32'h0002FFFD, 32'h0, db, dt, dr);
    csum_a = 32'h0002FFFD; csum_b = 32'h0;
    send_beat(cur_pkt[0]);
    send_beat(cur_pkt[1]);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    chk(m_if.tvalid == 1'b1, "latency_valid", 64'(m_if.tvalid), 64'd1);
    chk(m_if.tdata[79:72] == 8'h3F, "latency_ttl", 64'(m_if.tdata[79:72]), 64'h3F);
    wait_out(2);
    compare_clear();

    // 5-beat IPv4 packet under 1010 backpressure
    rdy_mode = 1;
    build_pkt(16'h0800, 8'h40, 16'hB861, 5);
    model_pkt(32'h0002FFFD, 32'h0, db, dt, dr);
    send_pkt(32'h0002FFFD, 32'h0);
    s_if.tvalid = 1'b0;
    wait_out(5);
    compare_clear();
    check_counters();

    // random back-to-back packets, first with free-flowing then random backpressure
    for (int r = 0; r < 2; r++) begin
      int total;
      total = 0;
      rdy_mode = (r == 0) ? 0 : 2;
      for (int p = 0; p < 20; p++) begin
        case ($urandom_range(0, 3))
          0:       et = 16'h0806;
          default: et = 16'h0800;
        endcase
        case ($urandom_range(0, 3))
          0:       rttl = 8'h00;
          1:       rttl = 8'h01;
          2:       rttl = 8'h02;
          default: rttl = 8'($urandom_range(3, 255));
        endcase
        build_pkt(et, rttl, 16'($urandom()), $urandom_range(1, 6));
        ra  = $urandom();
        r16 = 16'($urandom());
        if ($urandom_range(0, 9) < 7) rb = {r16, 16'(64'hFFFF - oc_fold({32'd0, ra} + {48'd0, r16}))};
        else                          rb = $urandom();
        model_pkt(ra, rb, db, dt, dr);
        e_bad += db; e_ttl += dt; e_runt += dr;
        total += cur_pkt.size();
        send_pkt(ra, rb);
      end
      s_if.tvalid = 1'b0;
      wait_out(total);
      compare_clear();
      check_counters();
    end

    // reset in the middle of a packet's payload, then a clean packet
    rdy_mode = 0;
    build_pkt(16'h0800, 8'h40, 16'hB861, 5);
    csum_a = 32'h0000FFFE; csum_b = 32'h0;
    send_beat(cur_pkt[0]);
    send_beat(cur_pkt[1]);
    send_beat(cur_pkt[2]);
    s_if.tdata = cur_pkt[3].data; s_if.tuser = cur_pkt[3].user; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk(s_if.tready == 1'b0, "midrst_s_tready", 64'(s_if.tready), 64'd0);
    chk(m_if.tvalid == 1'b0, "midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    out_q.delete(); exp_q.delete();
    e_bad = 0; e_ttl = 0; e_runt = 0;
    check_counters();
    @(negedge clk);
    chk(m_if.tvalid == 1'b0, "post_rst_no_stale", 64'(m_if.tvalid), 64'd0);
    @(posedge clk); #1;
    build_pkt(16'h0800, 8'h40, 16'hB861, 3);
    model_pkt(32'h0002FFFD, 32'h0, db, dt, dr);
    e_bad += db; e_ttl += dt; e_runt += dr;
    send_pkt(32'h0002FFFD, 32'h0);
    s_if.tvalid = 1'b0;
    wait_out(3);
    compare_clear();
    check_counters();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
